// File: rtl/frame_readout_ctrl.sv
// frame_readout_ctrl: arms on request, captures imager pixels, packs four per
// 32-bit FIFO word, flushes partial groups and reports frame status flags.
module frame_readout_ctrl #(
    parameter int PIXELS_PER_FRAME = 315392,
    parameter int ARM_TIMEOUT      = 10000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic        abort,
    input  logic        img_fval,
    input  logic        img_dval,
    input  logic [7:0]  img_data,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_din,
    output logic [2:0]  state,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow,
    output logic        short_frame,
    output logic        timeout,
    output logic [18:0] pix_count
);
    localparam int TW = $clog2(ARM_TIMEOUT + 1);
    localparam logic [18:0] PPF = 19'(PIXELS_PER_FRAME);
    localparam logic [TW-1:0] TLAST = TW'(ARM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        FLUSH   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [18:0]   pix_q, pix_d;
    logic [31:0]   word_q, word_d, out_q, out_d;
    logic [1:0]    lane_q, lane_d;
    logic          wr_q, wr_d;
    logic [TW-1:0] wait_q, wait_d;
    logic          ovf_q, ovf_d, short_q, short_d, tmo_q, tmo_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pix_q   <= '0;
            word_q  <= '0;
            out_q   <= '0;
            lane_q  <= '0;
            wr_q    <= 1'b0;
            wait_q  <= '0;
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            word_q  <= word_d;
            out_q   <= out_d;
            lane_q  <= lane_d;
            wr_q    <= wr_d;
            wait_q  <= wait_d;
            ovf_q   <= ovf_d;
            short_q <= short_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        word_d  = word_q;
        out_d   = out_q;
        lane_d  = lane_q;
        wr_d    = 1'b0;
        wait_d  = wait_q;
        ovf_d   = ovf_q | (wr_q & fifo_full);
        short_d = short_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: if (arm) begin
                state_d = ARMED;
                pix_d   = '0;
                word_d  = '0;
                lane_d  = '0;
                wait_d  = '0;
                ovf_d   = 1'b0;
                short_d = 1'b0;
                tmo_d   = 1'b0;
            end
            ARMED: begin
                if (img_fval) state_d = CAPTURE;
                else if (wait_q == TLAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else wait_d = wait_q + 1'b1;
            end
            CAPTURE: begin
                // Reaching the count waits one cycle so the final word is written first.
                if (pix_q == PPF) state_d = DONE;
                else if (!img_fval) begin
                    short_d = 1'b1;
                    state_d = FLUSH;
                end else if (img_dval) begin
                    pix_d = pix_q + 19'd1;
                    word_d[{lane_q, 3'b000} +: 8] = img_data;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        out_d  = {img_data, word_q[23:0]};
                        word_d = '0;
                        wr_d   = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (lane_q != 2'd0) begin
                    out_d  = word_q;
                    wr_d   = 1'b1;
                    lane_d = '0;
                    word_d = '0;
                end else state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            word_d  = '0;
            lane_d  = '0;
            wr_d    = 1'b0;
        end
    end

    assign fifo_wr_en  = wr_q & ~fifo_full;
    assign fifo_din    = out_q;
    assign state       = state_q;
    assign busy        = state_q != IDLE;
    assign frame_done  = state_q == DONE;
    assign overflow    = ovf_q;
    assign short_frame = short_q;
    assign timeout     = tmo_q;
    assign pix_count   = pix_q;
endmodule

// File: tb/tb_frame_readout_ctrl.sv
// tb_frame_readout_ctrl: directed vectors for full, short, overflow, timeout,
// abort and reset scenarios with hand-computed expected words and flags.
module tb_frame_readout_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0, abort = 1'b0, img_fval = 1'b0, img_dval = 1'b0, fifo_full = 1'b0;
    logic [7:0]  img_data = 8'h00;
    logic        fifo_wr_en, busy, frame_done, overflow, short_frame, timeout;
    logic [31:0] fifo_din;
    logic [2:0]  state;
    logic [18:0] pix_count;

    int          nvec = 0, nerr = 0, nw = 0, nd = 0;
    logic [31:0] words [0:15];

    frame_readout_ctrl #(.PIXELS_PER_FRAME(16), .ARM_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort),
        .img_fval(img_fval), .img_dval(img_dval), .img_data(img_data),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .state(state), .busy(busy), .frame_done(frame_done), .overflow(overflow),
        .short_frame(short_frame), .timeout(timeout), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fifo_wr_en) begin
            if (nw < 16) words[nw] = fifo_din;
            nw++;
        end
        if (frame_done) nd++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input string tag);
        nw = 0;
        nd = 0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk({tag, "_armed"}, 32'(state), 32'd1);
        img_fval = 1'b1;
        step();
        chk({tag, "_capture"}, 32'(state), 32'd2);
    endtask

    task automatic pixels(input int n, input logic [7:0] base, input int full_at);
        for (int i = 0; i < n; i++) begin
            img_dval  = 1'b1;
            img_data  = base + 8'(i);
            fifo_full = (i == full_at);
            step();
        end
        img_dval  = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20 && state != 3'd0; i++) step();
        chk(tag, 32'(state), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_wr"}, 32'(fifo_wr_en), 32'd0);
        chk({tag, "_din"}, fifo_din, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_flags"}, {29'd0, overflow, short_frame, timeout}, 32'd0);
        chk({tag, "_pix"}, 32'(pix_count), 32'd0);
    endtask

    initial begin
        step();
        step();
        chk_reset("por");
        reset = 1'b0;
        step();

        start("full");
        pixels(16, 8'h00, -1);
        chk("full_pix", 32'(pix_count), 32'd16);
        wait_idle("full_idle");
        img_fval = 1'b0;
        chk("full_nw", nw, 32'd4);
        chk("full_w0", words[0], 32'h03020100);
        chk("full_w1", words[1], 32'h07060504);
        chk("full_w3", words[3], 32'h0F0E0D0C);
        chk("full_nd", nd, 32'd1);
        chk("full_flags", {29'd0, overflow, short_frame, timeout}, 32'd0);

        start("short");
        pixels(6, 8'hA0, -1);
        img_fval = 1'b0;
        wait_idle("short_idle");
        chk("short_nw", nw, 32'd2);
        chk("short_w0", words[0], 32'hA3A2A1A0);
        chk("short_w1", words[1], 32'h0000A5A4);
        chk("short_flag", 32'(short_frame), 32'd1);
        chk("short_nd", nd, 32'd1);
        chk("short_pix", 32'(pix_count), 32'd6);

        start("ovf");
        pixels(16, 8'h00, 8);
        wait_idle("ovf_idle");
        img_fval = 1'b0;
        chk("ovf_nw", nw, 32'd3);
        chk("ovf_w1", words[1], 32'h0B0A0908);
        chk("ovf_flags", {29'd0, overflow, short_frame, timeout}, 32'd4);
        chk("ovf_nd", nd, 32'd1);

        nd = 0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        begin
            int n = 0;
            while (state != 3'd0 && n < 20) begin
                step();
                n++;
            end
            chk("tmo_cycles", n, 32'd8);
        end
        chk("tmo_flags", {29'd0, overflow, short_frame, timeout}, 32'd1);
        chk("tmo_nd", nd, 32'd0);

        start("abort");
        pixels(5, 8'h00, -1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_state", 32'(state), 32'd0);
        img_fval = 1'b0;
        step();
        step();
        chk("abort_nw", nw, 32'd1);
        chk("abort_nd", nd, 32'd0);
        start("again");
        pixels(4, 8'h10, -1);
        step();
        chk("again_w0", words[0], 32'h13121110);
        abort = 1'b1;
        step();
        abort = 1'b0;
        img_fval = 1'b0;

        start("rst");
        pixels(6, 8'hC0, -1);
        reset = 1'b1;
        #1;
        chk_reset("rst");
        img_fval = 1'b0;
        step();
        reset = 1'b0;
        step();
        step();
        chk("rst_nw", nw, 32'd1);
        chk("rst_w0", words[0], 32'hC3C2C1C0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
